// File: rtl/pe_border_feeder_if.sv
// Command, operand and PE-edge signal bundle for pe_border_feeder.
// The master modport is the feeder side; the slave modport is the job source / PE side.
interface pe_border_feeder_if #(
    parameter int IWIDTH = 8,
    parameter int LWIDTH = 8
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
    // the sender holds valid and its payload until that edge, and ready never depends on valid.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LWIDTH-1:0] cmd_len;
    logic              dat_valid;
    logic              dat_ready;
    logic [IWIDTH-1:0] dat_ifm;
    logic              dat_wsign;
    logic [IWIDTH-2:0] dat_wabs;

    logic [IWIDTH-1:0] ifm;
    logic              wght_sign;
    logic [IWIDTH-2:0] wght_abs;
    logic              en_i;
    logic              en_w;
    logic              en_o;
    logic              clr_i;
    logic              clr_w;
    logic              clr_o;
    logic              mac_done;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_len, dat_valid, dat_ifm, dat_wsign, dat_wabs,
        output cmd_ready, dat_ready, ifm, wght_sign, wght_abs,
               en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done, busy, done
    );

    modport slave (
        output cmd_valid, cmd_len, dat_valid, dat_ifm, dat_wsign, dat_wabs,
        input  cmd_ready, dat_ready, ifm, wght_sign, wght_abs,
               en_i, en_w, en_o, clr_i, clr_w, clr_o, mac_done, busy, done
    );
endinterface

// File: rtl/pe_border_feeder.sv
// Border-PE edge sequencer: clears the PE, streams (ifm, weight) pairs and holds en_o per product.
// Optional abort input and CLR_ABORT state are built when PE_FEEDER_ABORT_EN is defined.
module pe_border_feeder #(
    parameter int IWIDTH     = 8,
    parameter int MUL_CYCLES = 128,
    parameter int LWIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PE_FEEDER_ABORT_EN
    input  logic               abort,
`endif
    pe_border_feeder_if.master bus,
    output logic [2:0]         dbg_state
);
    localparam int CWIDTH = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CLR       = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_LOAD      = 3'd3;
    localparam logic [2:0] S_MAC       = 3'd4;
    localparam logic [2:0] S_FIN       = 3'd5;
`ifdef PE_FEEDER_ABORT_EN
    localparam logic [2:0] S_CLR_ABORT = 3'd6;
`endif

    logic [2:0]        state_q, state_d;
    logic [LWIDTH-1:0] rem_q, rem_d;
    logic [CWIDTH-1:0] cyc_q, cyc_d;
    logic [IWIDTH-1:0] ifm_q, ifm_d;
    logic              wsign_q, wsign_d;
    logic [IWIDTH-2:0] wabs_q, wabs_d;
    logic              en_iw_q, en_iw_d;
    logic              en_o_q, en_o_d;
    logic              clr_q, clr_d;
    logic              done_q, done_d;
    logic              dat_take;

`ifdef PE_FEEDER_ABORT_EN
    logic abort_req;
    assign abort_req     = abort && (state_q != S_IDLE);
    assign bus.dat_ready = (state_q == S_FETCH) && !abort_req;
`else
    assign bus.dat_ready = (state_q == S_FETCH);
`endif

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign dat_take      = bus.dat_valid && bus.dat_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cyc_d   = cyc_q;
        ifm_d   = ifm_q;
        wsign_d = wsign_q;
        wabs_d  = wabs_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    rem_d   = bus.cmd_len;
                    state_d = (bus.cmd_len == '0) ? S_FIN : S_CLR;
                end
            end
            S_CLR:   state_d = S_FETCH;
            S_FETCH: begin
                if (dat_take) begin
                    ifm_d   = bus.dat_ifm;
                    wsign_d = bus.dat_wsign;
                    wabs_d  = bus.dat_wabs;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cyc_d   = CWIDTH'(MUL_CYCLES - 1);
                state_d = S_MAC;
            end
            S_MAC: begin
                if (cyc_q == '0) begin
                    rem_d   = rem_q - LWIDTH'(1);
                    state_d = (rem_q == LWIDTH'(1)) ? S_FIN : S_FETCH;
                end else begin
                    cyc_d = cyc_q - CWIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PE_FEEDER_ABORT_EN
        if (abort_req) begin
            state_d = S_CLR_ABORT;
            rem_d   = '0;
            cyc_d   = '0;
        end
`endif
        // PE-facing strobes are registered copies of the next state, so they line up with state_q.
`ifdef PE_FEEDER_ABORT_EN
        clr_d = (state_d == S_CLR) || (state_d == S_CLR_ABORT);
`else
        clr_d = (state_d == S_CLR);
`endif
        en_iw_d = (state_d == S_LOAD);
        en_o_d  = (state_d == S_MAC);
        done_d  = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            cyc_q   <= '0;
            ifm_q   <= '0;
            wsign_q <= 1'b0;
            wabs_q  <= '0;
            en_iw_q <= 1'b0;
            en_o_q  <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            ifm_q   <= ifm_d;
            wsign_q <= wsign_d;
            wabs_q  <= wabs_d;
            en_iw_q <= en_iw_d;
            en_o_q  <= en_o_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

    assign bus.ifm       = ifm_q;
    assign bus.wght_sign = wsign_q;
    assign bus.wght_abs  = wabs_q;
    assign bus.en_i      = en_iw_q;
    assign bus.en_w      = en_iw_q;
    assign bus.en_o      = en_o_q;
    assign bus.clr_i     = clr_q;
    assign bus.clr_w     = clr_q;
    assign bus.clr_o     = clr_q;
    assign bus.mac_done  = done_q;
    assign bus.done      = done_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_pe_border_feeder.sv
// Randomized job/operand stimulus for pe_border_feeder, checked against a job-level timing model.
module tb_pe_border_feeder;
    localparam int IW  = 8;
    localparam int LW  = 8;
    localparam int MUL = 4;
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_border_feeder_if #(.IWIDTH(IW), .LWIDTH(LW)) bus ();
    logic [2:0] dbg_state;
`ifdef PE_FEEDER_ABORT_EN
    logic abort = 1'b0;
`endif

    pe_border_feeder #(.IWIDTH(IW), .MUL_CYCLES(MUL), .LWIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PE_FEEDER_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*IW-1:0] exp_q[$];
    logic [2*IW-1:0] cur_op;
    bit force_op = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [25:0] out_vec();
        return {bus.ifm, bus.wght_sign, bus.wght_abs, bus.en_i, bus.en_w, bus.en_o,
                bus.clr_i, bus.clr_w, bus.clr_o, bus.mac_done, bus.done, bus.busy, bus.dat_ready};
    endfunction

    task automatic new_op();
        if (force_op) cur_op = {8'hFD, 1'b1, 7'd5};
        else          cur_op = (2*IW)'($urandom);
        bus.dat_ifm   = cur_op[2*IW-1:IW];
        bus.dat_wsign = cur_op[IW-1];
        bus.dat_wabs  = cur_op[IW-2:0];
    endtask

    // Called at a negedge with the feeder idle (or about to be); returns at the negedge after done.
    task automatic run_job(input int len, input int gap_pct, input bit bp, input bit keep_cmd, input int next_len);
        int t_hs, t_done, t_clr, n_clr, n_eni, n_eno, n_cons, run, gap_left, fetch_wait;
        int bad_sig, bad_ovl, bad_busy, bad_ready, exp_lat;
        bit consumed;
        logic [2*IW-1:0] last_op;
        t_hs = -1; t_done = -1; t_clr = -1; n_clr = 0; n_eni = 0; n_eno = 0; n_cons = 0;
        run = 0; gap_left = 0; fetch_wait = 0; bad_sig = 0; bad_ovl = 0; bad_busy = 0; bad_ready = 0;
        last_op = '0;
        exp_q.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        if (!bus.dat_valid) begin
            new_op();
            bus.dat_valid = ($urandom_range(99) >= gap_pct);
        end
        for (int t = 0; t < LIMIT; t++) begin
            if (t_hs < 0 && bus.cmd_valid && bus.cmd_ready) t_hs = t;
            consumed = bus.dat_valid && bus.dat_ready;
            if (consumed) begin
                exp_q.push_back(cur_op);
                n_cons++;
            end
            if (bus.dat_ready && !bus.dat_valid) fetch_wait++;
            @(negedge clk);
            if (t_hs == t) begin
                if (keep_cmd) bus.cmd_len = LW'(next_len);
                else          bus.cmd_valid = 1'b0;
            end
            if (consumed || !bus.dat_valid) begin
                if (consumed) new_op();
                if (bp && consumed && n_cons == 1) gap_left = 5;
                if (gap_left > 0) begin
                    bus.dat_valid = 1'b0;
                    if (bus.dat_ready) gap_left--;
                end else begin
                    bus.dat_valid = ($urandom_range(99) >= gap_pct);
                end
            end
            // Observe the cycle that follows the posedge just taken.
            if (t_hs >= 0 && !bus.busy) bad_busy++;
            if (bus.busy && bus.cmd_ready) bad_ready++;
            if (bus.mac_done !== bus.done) bad_sig++;
            if (bus.clr_i !== bus.clr_w || bus.clr_i !== bus.clr_o) bad_sig++;
            if (bus.en_i !== bus.en_w) bad_sig++;
            if (bus.clr_i) begin
                n_clr++;
                t_clr = t + 1;
            end
            if (bus.en_i) begin
                n_eni++;
                check("op_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    last_op = exp_q.pop_front();
                    check("op_loaded", {bus.ifm, bus.wght_sign, bus.wght_abs}, last_op);
                end
            end
            if (bus.en_o) begin
                n_eno++;
                run++;
                if (bus.en_i || bus.en_w || bus.dat_ready) bad_ovl++;
            end else if (run > 0) begin
                check("en_o_run", run, MUL);
                run = 0;
            end
            if (bus.done) begin
                t_done = t + 1;
                if (len > 0) check("op_hold", {bus.ifm, bus.wght_sign, bus.wght_abs}, last_op);
                break;
            end
        end
        check("done_seen", t_done >= 0, 1);
        check("cmd_taken", t_hs >= 0, 1);
        exp_lat = (len == 0) ? 1 : 2 + len * (2 + MUL);
        if (gap_pct == 0 && !bp && t_done >= 0 && t_hs >= 0) check("latency", t_done - t_hs, exp_lat);
        if (t_done >= 0 && t_hs >= 0) check("latency_min", (t_done - t_hs) >= exp_lat, 1);
        check("n_clr", n_clr, (len > 0) ? 1 : 0);
        if (len > 0) check("clr_pos", t_clr - t_hs, 1);
        check("n_en_i", n_eni, len);
        check("n_en_o", n_eno, len * MUL);
        check("n_consumed", n_cons, len);
        check("sig_pairs", bad_sig, 0);
        check("en_overlap", bad_ovl, 0);
        check("busy_in_job", bad_busy, 0);
        check("ready_while_busy", bad_ready, 0);
        if (bp) check("bp_fetch_wait", fetch_wait >= 5, 1);
        @(negedge clk);
        check("idle_busy", bus.busy, 0);
        check("idle_ready", bus.cmd_ready, 1);
        check("idle_done", {bus.done, bus.mac_done}, 0);
    endtask

    task automatic start_job_wait_mac(input int len);
        int b;
        bus.cmd_valid = 1'b1;
        bus.cmd_len   = LW'(len);
        bus.dat_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        b = 0;
        while (!bus.en_o && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("reach_mac", bus.en_o, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.dat_valid = 1'b0;
        bus.dat_ifm   = '0;
        bus.dat_wsign = 1'b0;
        bus.dat_wabs  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_outs", out_vec(), 0);
        check("rst_ready", bus.cmd_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outs", out_vec(), 0);
        check("idle_cmd_ready", bus.cmd_ready, 1);

        force_op = 1'b1;
        run_job(1, 0, 1'b0, 1'b0, 0);
        force_op = 1'b0;
        run_job(0, 0, 1'b0, 1'b0, 0);
        run_job(3, 0, 1'b1, 1'b0, 0);
        run_job(2, 0, 1'b0, 1'b1, 1);
        run_job(1, 0, 1'b0, 1'b0, 0);
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(0, 4), $urandom_range(0, 60), 1'b0, 1'b0, 0);
        end

        start_job_wait_mac(2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outs", out_vec(), 0);
        check("rst_mid_ready", bus.cmd_ready, 1);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.mac_done || bus.busy) n++;
        end
        check("rst_mid_no_done", n, 0);

`ifdef PE_FEEDER_ABORT_EN
        start_job_wait_mac(2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_clr", {bus.clr_i, bus.clr_w, bus.clr_o}, 3'b111);
        check("abort_en", {bus.en_i, bus.en_w, bus.en_o}, 0);
        check("abort_no_done", {bus.done, bus.mac_done}, 0);
        @(negedge clk);
        check("abort_idle", bus.cmd_ready, 1);
        check("abort_clr_end", bus.clr_i, 0);
        check("abort_no_done2", {bus.done, bus.mac_done}, 0);
`endif
        bus.dat_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
